// File: rtl/sram_loader_pkg.sv
// Shared types and constants for the SRAM boot loader.
// CSUM states exist only when SRAM_LOADER_CHECKSUM_EN is defined.
package sram_loader_pkg;

  localparam int MAX_WORDS = 256;
  localparam int PAGE_W    = 8;
  localparam int WORD_W    = 16;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_LEN_HI  = 4'd1,
    ST_LEN_LO  = 4'd2,
    ST_DATA_HI = 4'd3,
    ST_DATA_LO = 4'd4,
    ST_WRITE   = 4'd5,
    ST_HOLD    = 4'd6,
`ifdef SRAM_LOADER_CHECKSUM_EN
    ST_CSUM_HI = 4'd7,
    ST_CSUM_LO = 4'd8,
`endif
    ST_DONE    = 4'd9,
    ST_ERROR   = 4'd10
  } state_e;

  function automatic logic takes_byte(input state_e s);
    logic r;
    case (s)
      ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO: r = 1'b1;
`ifdef SRAM_LOADER_CHECKSUM_EN
      ST_CSUM_HI, ST_CSUM_LO: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_busy(input state_e s);
    logic r;
    case (s)
      ST_IDLE, ST_DONE, ST_ERROR: r = 1'b0;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sram_loader_if.sv
// Byte-stream input and SRAM write bus of the loader.
// The loader uses the slave modport; the byte source / SRAM model uses master.
interface sram_loader_if;
  import sram_loader_pkg::*;

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [WORD_W-1:0] SRAM_ADDR;
  logic [WORD_W-1:0] SRAM_DATA;
  logic              SRAM_WE;

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, SRAM_ADDR, SRAM_DATA, SRAM_WE
  );

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, SRAM_ADDR, SRAM_DATA, SRAM_WE
  );
endinterface

// File: rtl/sram_write_strobe.sv
// WRITE/HOLD sequencer: WE high for WE_CYCLES cycles after start_i, then one
// hold cycle flagged by done_o. last_o marks the final WE cycle.
module sram_write_strobe #(
  parameter int WE_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  output logic we_o,
  output logic last_o,
  output logic done_o
);
  logic [3:0] cnt_q;
  logic       we_q;
  logic       hold_q;

  // Strobe counter: load on start, count down while WE is high, then one hold cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= 4'd0;
      we_q   <= 1'b0;
      hold_q <= 1'b0;
    end else if (start_i) begin
      cnt_q  <= 4'(WE_CYCLES - 1);
      we_q   <= 1'b1;
      hold_q <= 1'b0;
    end else if (we_q) begin
      if (cnt_q == 4'd0) begin
        we_q   <= 1'b0;
        hold_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q - 4'd1;
      end
    end else begin
      hold_q <= 1'b0;
    end
  end

  assign we_o   = we_q;
  assign last_o = we_q && (cnt_q == 4'd0);
  assign done_o = hold_q;
endmodule

// File: rtl/sram_loader.sv
// Boot loader: length word + N big-endian data words -> one SRAM page, then go.
// Define SRAM_LOADER_CHECKSUM_EN to require a trailing 16-bit sum of the data.
module sram_loader
  import sram_loader_pkg::*;
#(
  parameter int WE_CYCLES = 1,
  parameter int TIMEOUT   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [PAGE_W-1:0] page,
  sram_loader_if.slave      bus,
  output logic              go,
  output logic              busy,
  output logic              error,
  output logic [8:0]        words_written
);
  state_e            state_q, state_d;
  logic [PAGE_W-1:0] page_q, page_d;
  logic [8:0]        ww_q, ww_d;
  logic [8:0]        len_q, len_d;
  logic [7:0]        hi_q, hi_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [31:0]       idle_q, idle_d;
  logic              ready_q, busy_q, err_q, go_q;
  logic              accept_s, wr_start_s, wr_last_s, wr_done_s, we_s;
  logic [WORD_W-1:0] word_s;
`ifdef SRAM_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] sum_q, sum_d;
`endif

  assign accept_s = bus.rx_valid && ready_q;
  assign word_s   = {hi_q, bus.rx_data};

  sram_write_strobe #(.WE_CYCLES(WE_CYCLES)) u_strobe (
    .clk    (clk),
    .reset  (reset),
    .start_i(wr_start_s),
    .we_o   (we_s),
    .last_o (wr_last_s),
    .done_o (wr_done_s)
  );

  // Next-state logic for the load sequence and the inter-byte timeout.
  always_comb begin
    state_d    = state_q;
    page_d     = page_q;
    ww_d       = ww_q;
    len_d      = len_q;
    hi_d       = hi_q;
    addr_d     = addr_q;
    data_d     = data_q;
    idle_d     = idle_q;
    wr_start_s = 1'b0;
`ifdef SRAM_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (start) begin
          state_d = ST_LEN_HI;
          page_d  = page;
          ww_d    = 9'd0;
`ifdef SRAM_LOADER_CHECKSUM_EN
          sum_d   = 16'd0;
`endif
        end else begin
          state_d = state_q;
        end
      end
      ST_LEN_HI, ST_DATA_HI: begin
        if (accept_s) begin
          hi_d    = bus.rx_data;
          state_d = (state_q == ST_LEN_HI) ? ST_LEN_LO : ST_DATA_LO;
        end else begin
          state_d = state_q;
        end
      end
      ST_LEN_LO: begin
        if (accept_s) begin
          if ((word_s != 16'd0) && (word_s <= 16'(MAX_WORDS))) begin
            len_d   = word_s[8:0];
            state_d = ST_DATA_HI;
          end else begin
            state_d = ST_ERROR;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_DATA_LO: begin
        if (accept_s) begin
          state_d    = ST_WRITE;
          wr_start_s = 1'b1;
          addr_d     = {page_q, ww_q[7:0]};
          data_d     = word_s;
`ifdef SRAM_LOADER_CHECKSUM_EN
          sum_d      = sum_q + word_s;
`endif
        end else begin
          state_d = state_q;
        end
      end
      ST_WRITE: begin
        if (wr_last_s) state_d = ST_HOLD;
        else           state_d = ST_WRITE;
      end
      ST_HOLD: begin
        if (wr_done_s) begin
          ww_d   = ww_q + 9'd1;
          addr_d = 16'd0;
          data_d = 16'd0;
          if (ww_q + 9'd1 == len_q) begin
`ifdef SRAM_LOADER_CHECKSUM_EN
            state_d = ST_CSUM_HI;
`else
            state_d = ST_DONE;
`endif
          end else begin
            state_d = ST_DATA_HI;
          end
        end else begin
          state_d = ST_HOLD;
        end
      end
`ifdef SRAM_LOADER_CHECKSUM_EN
      ST_CSUM_HI: begin
        if (accept_s) begin
          hi_d    = bus.rx_data;
          state_d = ST_CSUM_LO;
        end else begin
          state_d = state_q;
        end
      end
      ST_CSUM_LO: begin
        if (accept_s) state_d = (word_s == sum_q) ? ST_DONE : ST_ERROR;
        else          state_d = state_q;
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Idle counter only runs while waiting for a byte; WRITE/HOLD reset it.
    if ((TIMEOUT > 0) && takes_byte(state_q)) begin
      if (accept_s) begin
        idle_d = 32'd0;
      end else if (idle_q == 32'(TIMEOUT - 1)) begin
        idle_d  = 32'd0;
        state_d = ST_ERROR;
      end else begin
        idle_d = idle_q + 32'd1;
      end
    end else begin
      idle_d = 32'd0;
    end
  end

  // State, datapath and outputs; outputs are decoded from the next state so they align with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      page_q  <= 8'd0;
      ww_q    <= 9'd0;
      len_q   <= 9'd0;
      hi_q    <= 8'd0;
      addr_q  <= 16'd0;
      data_q  <= 16'd0;
      idle_q  <= 32'd0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      go_q    <= 1'b0;
`ifdef SRAM_LOADER_CHECKSUM_EN
      sum_q   <= 16'd0;
`endif
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      ww_q    <= ww_d;
      len_q   <= len_d;
      hi_q    <= hi_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      idle_q  <= idle_d;
      ready_q <= takes_byte(state_d);
      busy_q  <= is_busy(state_d);
      err_q   <= (state_d == ST_ERROR);
      go_q    <= (state_d == ST_DONE);
`ifdef SRAM_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign bus.rx_ready  = ready_q;
  assign bus.SRAM_ADDR = addr_q;
  assign bus.SRAM_DATA = data_q;
  assign bus.SRAM_WE   = we_s;
  assign go            = go_q;
  assign busy          = busy_q;
  assign error         = err_q;
  assign words_written = ww_q;
endmodule

// File: tb/tb_sram_loader.sv
// Self-checking bench for sram_loader: unit 0 (WE_CYCLES=1, TIMEOUT=0),
// unit 1 (WE_CYCLES=4, TIMEOUT=100). Honours SRAM_LOADER_CHECKSUM_EN.
module tb_sram_loader;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       st [2];
  logic [7:0] pg [2];
  logic [7:0] rxd [2];
  logic       rxv [2];
  logic       rdy [2], we [2], go_w [2], busy_w [2], err_w [2];
  logic [15:0] ad [2], dt [2];
  logic [8:0]  ww [2];

  sram_loader_if bus0 ();
  sram_loader_if bus1 ();

  assign bus0.rx_data = rxd[0];
  assign bus0.rx_valid = rxv[0];
  assign bus1.rx_data = rxd[1];
  assign bus1.rx_valid = rxv[1];
  assign rdy[0] = bus0.rx_ready;
  assign rdy[1] = bus1.rx_ready;
  assign we[0] = bus0.SRAM_WE;
  assign we[1] = bus1.SRAM_WE;
  assign ad[0] = bus0.SRAM_ADDR;
  assign ad[1] = bus1.SRAM_ADDR;
  assign dt[0] = bus0.SRAM_DATA;
  assign dt[1] = bus1.SRAM_DATA;

  sram_loader #(.WE_CYCLES(1), .TIMEOUT(0)) dut0 (
    .clk(clk), .reset(rst), .start(st[0]), .page(pg[0]), .bus(bus0),
    .go(go_w[0]), .busy(busy_w[0]), .error(err_w[0]), .words_written(ww[0])
  );
  sram_loader #(.WE_CYCLES(4), .TIMEOUT(100)) dut1 (
    .clk(clk), .reset(rst), .start(st[1]), .page(pg[1]), .bus(bus1),
    .go(go_w[1]), .busy(busy_w[1]), .error(err_w[1]), .words_written(ww[1])
  );

  int checks = 0, failures = 0;
  int mon_checks = 0, mon_fail = 0;
  logic [32:0] exp_w [$];          // {unit, addr, data} in write order
  logic [15:0] sram_img [0:65535];
  int go_seen [2];
  int we_len [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  task automatic mchk(input string nm, input logic [31:0] act, input logic [31:0] req);
    mon_checks++;
    if (act !== req) begin
      mon_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, req, $time);
    end
  endtask

  // Cycle monitor: every write must match the expected queue, last WE_CYCLES, then hold one cycle.
  initial begin
    for (int u = 0; u < 2; u++) begin
      go_seen[u] = 0;
      we_len[u]  = 0;
    end
    forever begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        if (rst) begin
          we_len[u] = 0;
        end else if (we[u]) begin
          mchk("ready_low_in_write", 32'(rdy[u]), 32'd0);
          if (exp_w.size() == 0) begin
            mchk("unexpected_write", 32'd1, 32'd0);
          end else begin
            mchk("write_unit", 32'(exp_w[0][32]), 32'(u));
            mchk("write_addr_data", {ad[u], dt[u]}, exp_w[0][31:0]);
          end
          sram_img[ad[u]] = dt[u];
          we_len[u]++;
        end else if (we_len[u] != 0) begin
          mchk("we_width", 32'(we_len[u]), (u == 0) ? 32'd1 : 32'd4);
          mchk("ready_low_in_hold", 32'(rdy[u]), 32'd0);
          if (exp_w.size() != 0) begin
            mchk("hold_addr_data", {ad[u], dt[u]}, exp_w[0][31:0]);
            void'(exp_w.pop_front());
          end
          we_len[u] = 0;
        end else begin
          mchk("idle_bus_zero", {ad[u], dt[u]}, 32'd0);
        end
        if (!rst && go_w[u]) begin
          go_seen[u]++;
          mchk("go_outside_busy", {31'd0, busy_w[u]}, 32'd0);
        end
      end
    end
  end

  task automatic do_start(input int u, input logic [7:0] p);
    st[u] = 1'b1;
    pg[u] = p;
    @(negedge clk);
    st[u] = 1'b0;
  endtask

  // Offer one byte after an optional gap; returns at the negedge following acceptance.
  task automatic send_byte(input int u, input logic [7:0] b, input int gap);
    bit got;
    got = 1'b0;
    if (gap > 0) begin
      rxv[u] = 1'b0;
      repeat (gap) @(negedge clk);
    end
    rxv[u] = 1'b1;
    rxd[u] = b;
    for (int k = 0; k < 300; k++) begin
      if (rdy[u]) begin
        @(negedge clk);
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) chk("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int u);
    int k;
    k = 0;
    while (busy_w[u] && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("done_within_budget", 32'(busy_w[u]), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  // Model: build the stream from the words, queue the writes it must cause, then check the outcome.
  task automatic run_load(input int u, input logic [7:0] p, input logic [15:0] w [$],
                          input logic [15:0] cs_delta, input bit rnd,
                          input int stall_at, input int stall_len);
    logic [7:0] b [$];
    int n, g0, gap;
    bit ok;
    n = w.size();
    b.push_back(8'(n >> 8));
    b.push_back(8'(n));
    foreach (w[i]) begin
      b.push_back(w[i][15:8]);
      b.push_back(w[i][7:0]);
      exp_w.push_back({1'(u), p, 8'(i), w[i]});
    end
    ok = (cs_delta == 16'd0);
`ifdef SRAM_LOADER_CHECKSUM_EN
    begin
      logic [15:0] sum;
      sum = 16'd0;
      foreach (w[i]) sum = sum + w[i];
      sum = sum + cs_delta;
      b.push_back(sum[15:8]);
      b.push_back(sum[7:0]);
    end
`endif
    g0 = go_seen[u];
    do_start(u, p);
    chk("start_clears_error", 32'(err_w[u]), 32'd0);
    chk("busy_after_start", 32'(busy_w[u]), 32'd1);
    foreach (b[i]) begin
      gap = (i == stall_at) ? stall_len : (rnd ? int'($urandom_range(4, 0)) : 0);
      send_byte(u, b[i], gap);
    end
    rxv[u] = 1'b0;
    wait_idle(u);
    chk("go_count", 32'(go_seen[u] - g0), ok ? 32'd1 : 32'd0);
    chk("error_flag", 32'(err_w[u]), ok ? 32'd0 : 32'd1);
    chk("words_written", 32'(ww[u]), 32'(n));
    chk("all_writes_seen", 32'(exp_w.size()), 32'd0);
  endtask

  task automatic bad_len(input int u, input logic [7:0] hi, input logic [7:0] lo);
    int g0;
    g0 = go_seen[u];
    do_start(u, 8'h20);
    send_byte(u, hi, 0);
    send_byte(u, lo, 0);
    rxv[u] = 1'b0;
    repeat (3) @(negedge clk);
    chk("badlen_error", 32'(err_w[u]), 32'd1);
    chk("badlen_busy_ready", {30'd0, busy_w[u], rdy[u]}, 32'd0);
    chk("badlen_no_go", 32'(go_seen[u] - g0), 32'd0);
    chk("badlen_words", 32'(ww[u]), 32'd0);
  endtask

  logic [15:0] wq [$];
  int g1;

  initial begin
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      st[u] = 1'b0; pg[u] = 8'd0; rxd[u] = 8'd0; rxv[u] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk("reset_ctrl", {18'd0, rdy[u], we[u], go_w[u], busy_w[u], err_w[u], ww[u]}, 32'd0);
      chk("reset_bus", {ad[u], dt[u]}, 32'd0);
    end

    // Basic load, with literal pins on the result.
    wq.delete();
    wq.push_back(16'h1234); wq.push_back(16'hABCD); wq.push_back(16'h0001);
    g1 = go_seen[0];
    run_load(0, 8'h12, wq, 16'd0, 1'b0, -1, 0);
    chk("t1_mem_1200", 32'(sram_img[16'h1200]), 32'h1234);
    chk("t1_mem_1201", 32'(sram_img[16'h1201]), 32'hABCD);
    chk("t1_mem_1202", 32'(sram_img[16'h1202]), 32'h0001);
    chk("t1_words", 32'(ww[0]), 32'd3);
    chk("t1_single_go", 32'(go_seen[0] - g1), 32'd1);

    // Bad lengths 0 and 257, then a start clears error.
    bad_len(0, 8'h00, 8'h00);
    bad_len(0, 8'h01, 8'h01);
    wq.delete();
    wq.push_back(16'hBEEF);
    run_load(0, 8'h21, wq, 16'd0, 1'b0, -1, 0);

    // Full page, N=256 ends at offset 0xFF.
    wq.delete();
    for (int i = 0; i < 256; i++) wq.push_back({8'(i), ~8'(i)});
    run_load(0, 8'h3C, wq, 16'd0, 1'b0, -1, 0);
    chk("full_first", 32'(sram_img[16'h3C00]), 32'h00FF);
    chk("full_last", 32'(sram_img[16'h3CFF]), 32'hFF00);
    chk("full_words", 32'(ww[0]), 32'd256);

    // Random valid gaps and bytes offered through WRITE/HOLD, 4-cycle strobe.
    wq.delete();
    for (int i = 0; i < 20; i++) wq.push_back(16'(i * 16'h1357 + 16'h0F0F));
    run_load(1, 8'hA5, wq, 16'd0, 1'b1, -1, 0);
    chk("stall_mem_A513", 32'(sram_img[16'hA513]), 32'(16'(19 * 16'h1357 + 16'h0F0F)));

`ifdef SRAM_LOADER_CHECKSUM_EN
    wq.delete();
    wq.push_back(16'h0001); wq.push_back(16'h0002);
    run_load(0, 8'h50, wq, 16'd0, 1'b0, -1, 0);
    g1 = go_seen[0];
    run_load(0, 8'h51, wq, 16'd1, 1'b0, -1, 0);
    chk("csum_bad_no_go", 32'(go_seen[0] - g1), 32'd0);
`endif

    // TIMEOUT=0: a 10000-cycle stall after one data byte still completes.
    wq.delete();
    wq.push_back(16'h1234); wq.push_back(16'h5678);
    run_load(0, 8'h40, wq, 16'd0, 1'b0, 3, 10000);

    // TIMEOUT=100: error exactly after 100 idle cycles in DATA_LO.
    g1 = go_seen[1];
    do_start(1, 8'h66);
    send_byte(1, 8'h00, 0);
    send_byte(1, 8'h01, 0);
    send_byte(1, 8'hAA, 0);
    rxv[1] = 1'b0;
    repeat (99) @(negedge clk);
    chk("timeout_not_early", {30'd0, err_w[1], busy_w[1]}, 32'd1);
    @(negedge clk);
    chk("timeout_error", {30'd0, err_w[1], busy_w[1]}, 32'd2);
    chk("timeout_no_go", 32'(go_seen[1] - g1), 32'd0);

    // Reset in the middle of a 4-cycle write.
    g1 = go_seen[1];
    do_start(1, 8'h77);
    exp_w.push_back({1'b1, 16'h7700, 16'h1122});
    send_byte(1, 8'h00, 0);
    send_byte(1, 8'h02, 0);
    send_byte(1, 8'h11, 0);
    send_byte(1, 8'h22, 0);
    rxv[1] = 1'b0;
    chk("write_in_progress", 32'(we[1]), 32'd1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_ctrl", {18'd0, rdy[1], we[1], go_w[1], busy_w[1], err_w[1], ww[1]}, 32'd0);
    chk("rst_bus", {ad[1], dt[1]}, 32'd0);
    repeat (2) @(negedge clk);
    exp_w.delete();
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_no_go", 32'(go_seen[1] - g1), 32'd0);
    chk("rst_idle", {30'd0, busy_w[1], we[1]}, 32'd0);

    checks = checks + mon_checks;
    failures = failures + mon_fail;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
